dffr_shift_tx: RTL
==================

DFFR_SHIFT_TX -- requirements
Module: dffr_shift_tx

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, serialised word width (legal range 2..32).
REQ-002 SHALL have port: CK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RN  input  1  asynchronous active-low reset (clear); the only reset.
REQ-004 SHALL have port: D  input  WIDTH  parallel word to transmit.
REQ-005 SHALL have port: LOAD_VALID  input  1  D is valid this cycle.
REQ-006 SHALL have port: LOAD_READY  output  1  block accepts D this cycle.
REQ-007 SHALL have port: HOLD  input  1  stall shifting (freeze) while high.
REQ-008 SHALL have port: Q  output  1  serial data, MSB first, registered.
REQ-009 SHALL have port: QN  output  1  always the logical inverse of Q.
REQ-010 SHALL have port: BUSY  output  1  high while a word is on Q (state SHIFT).
REQ-011 SHALL have port: LAST  output  1  high while the final bit (D[0]) of a word is on Q.

Function
REQ-012 SHALL implement two states: IDLE, SHIFT; plus WIDTH-bit shift register SR and bit counter CNT of ceil(log2(WIDTH)) bits.
REQ-013 SHALL drive LOAD_READY = 1 in IDLE; = 1 in SHIFT only when CNT==0 and HOLD==0; else 0 (combinational from state, CNT, HOLD).
REQ-014 SHALL accept a word on a rising CK edge where LOAD_VALID & LOAD_READY; D sampled only then, ignored otherwise.
REQ-015 On accept: SR <= D, Q <= D[WIDTH-1], CNT <= WIDTH-1, state <= SHIFT; first bit on Q the cycle after accept (latency 1).
REQ-016 In SHIFT with HOLD==0 and CNT!=0: SR shifts left one bit, Q <= next lower bit, CNT <= CNT-1.
REQ-017 In SHIFT with HOLD==1: SR, Q, CNT, state unchanged; any number of hold cycles SHALL NOT drop or repeat bits beyond the held cycles.
REQ-018 In SHIFT with CNT==0, HOLD==0, no accept: state <= IDLE, Q <= 0.
REQ-019 In SHIFT with CNT==0, HOLD==0, accept: back-to-back reload per REQ-015 with no idle bubble; Q goes D[0] of old word -> D[WIDTH-1] of new word on consecutive cycles.
REQ-020 In IDLE without accept: Q held at 0, SR and CNT hold.
REQ-021 BUSY SHALL equal (state==SHIFT); LAST SHALL equal (state==SHIFT && CNT==0), including during HOLD.
REQ-022 Each accepted word SHALL occupy exactly WIDTH non-held cycles on Q; no X SHALL propagate to outputs once RN is high and inputs are known.
REQ-023 HOLD in IDLE SHALL have no effect; acceptance in IDLE is not gated by HOLD.

Reset
REQ-024 RN low SHALL, immediately and independent of CK, force state IDLE, SR 0, CNT 0, Q 0, QN 1, BUSY 0, LAST 0, LOAD_READY 1.
REQ-025 RN low mid-word SHALL abort the word; no remaining bits are emitted after release.
REQ-026 While RN is low, CK edges and LOAD_VALID SHALL be ignored; first accept possible on the first rising CK edge with RN high.

Verification
REQ-027 Reset: RN=0 asynchronously mid-cycle -> Q=0, QN=1, BUSY=0, LOAD_READY=1 without a CK edge.
REQ-028 Single word: WIDTH=8, D=8'hA5 accepted, HOLD=0 -> Q = 1,0,1,0,0,1,0,1 on cycles 1..8, LAST only on cycle 8, BUSY 8 cycles, Q=0 cycle 9.
REQ-029 Back-to-back: 8'hF0 then 8'h0F with LOAD_VALID held -> 16 contiguous bits 1111000000001111, LOAD_READY high only in IDLE and each LAST cycle.
REQ-030 Hold: D=8'hC3, HOLD=1 for 3 cycles after bit 2 -> bit 2 (0) held 4 cycles total, sequence otherwise 11000011, BUSY 11 cycles.
REQ-031 Hold on last bit: HOLD=1 during LAST with LOAD_VALID=1 -> LOAD_READY=0, no accept until HOLD drops; then reload next edge.
REQ-032 Abort: RN pulsed low after bit 3 of 8'hFF -> Q=0 immediately, BUSY=0, next word 8'h81 transmits cleanly as 10000001.

Source files
------------

// File: rtl/dffr_shift_tx.sv
// dffr_shift_tx: parallel-in, serial-out transmitter, MSB first, with hold and back-to-back reload
//   CK         in   clock, rising edge
//   RN         in   asynchronous active-low clear
//   D          in   WIDTH-bit word to transmit
//   LOAD_VALID in   D is valid this cycle
//   LOAD_READY out  word is accepted on the next edge if LOAD_VALID is high
//   HOLD       in   freeze shifting while high
//   Q / QN     out  registered serial data and its inverse
//   BUSY       out  a word is on Q
//   LAST       out  the final bit of a word is on Q
module dffr_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic             HOLD,
    output logic             Q,
    output logic             QN,
    output logic             BUSY,
    output logic             LAST
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             accept;

    // Ready on the last bit lets a new word follow with no idle bubble.
    assign LOAD_READY = (state_q == IDLE) || (cnt_q == '0 && !HOLD);
    assign accept     = LOAD_VALID && LOAD_READY;
    assign Q          = q_q;
    assign QN         = ~q_q;
    assign BUSY       = state_q == SHIFT;
    assign LAST       = state_q == SHIFT && cnt_q == '0;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        if (accept) begin
            state_d = SHIFT;
            sr_d    = D;
            cnt_d   = CW'(WIDTH - 1);
            q_d     = D[WIDTH-1];
        end else if (state_q == SHIFT && !HOLD) begin
            if (cnt_q != '0) begin
                sr_d  = sr_q << 1;
                q_d   = sr_q[WIDTH-2];
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = IDLE;
                q_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end
endmodule
